// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction ROM and offers {fetch_exc, pc+4, pc} to ID.
// Optional misaligned-fetch reporting is enabled by defining IF_MISALIGN_CHECK_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allow_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_target,
    input  logic        mret_valid,
    input  logic [31:0] mret_target,
    output logic [31:0] irom_addr,
    output logic        irom_en,
    output logic [64:0] if_to_id_bus,
    output logic        if_to_id_valid
);

    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] pc4;
    logic [31:0] redirect_target;
    logic [31:0] pc_next;
    logic        redirect;
    logic        advance;
    logic        fetch_exc;
    logic        seq_step;

    assign pc4      = pc + 32'd4;
    assign redirect = trap_valid | mret_valid | br_taken;

    always_comb begin
        redirect_target = br_target;
        if (trap_valid) begin
            redirect_target = trap_target;
        end else if (mret_valid) begin
            redirect_target = mret_target;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    // A misaligned PC is still offered so the trap unit sees it, but is never read from ROM or stepped past.
    assign fetch_exc = (pc[1:0] != 2'b00);
`else
    assign fetch_exc = 1'b0;
`endif

    assign if_to_id_valid = if_valid & ~redirect;
    assign advance        = id_allow_in & if_to_id_valid;
    assign seq_step       = advance & ~fetch_exc;
    assign irom_en        = seq_step;
    assign irom_addr      = pc;
    assign if_to_id_bus   = {fetch_exc, pc4, pc};

    always_comb begin
        pc_next = pc;
        if (redirect) begin
`ifdef IF_MISALIGN_CHECK_EN
            pc_next = redirect_target;
`else
            pc_next = {redirect_target[31:2], 2'b00};
`endif
        end else if (seq_step) begin
            pc_next = pc4;
        end
    end

    // fetch PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            if_valid <= 1'b0;
        end else begin
            pc       <= pc_next;
            if_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a behavioural fetch model,
// plus literal expectations for reset, sequencing, stalls, redirect priority, wrap and async reset.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        id_allow_in;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        mret_valid;
    logic [31:0] mret_target;
    logic [31:0] irom_addr;
    logic        irom_en;
    logic [64:0] if_to_id_bus;
    logic        if_to_id_valid;

    int npass;
    int ntotal;

    // model state: the address the stage is currently presenting and whether a slot exists yet
    logic [31:0] m_pc;
    logic        m_valid;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_allow_in    (id_allow_in),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .trap_valid     (trap_valid),
        .trap_target    (trap_target),
        .mret_valid     (mret_valid),
        .mret_target    (mret_target),
        .irom_addr      (irom_addr),
        .irom_en        (irom_en),
        .if_to_id_bus   (if_to_id_bus),
        .if_to_id_valid (if_to_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        ntotal++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic misaligned(input logic [31:0] a);
`ifdef IF_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge: apply inputs, compare every output with the model, advance the model over the next edge.
    task automatic step(input logic allow, input logic br, input logic [31:0] bt,
                        input logic tr, input logic [31:0] tt,
                        input logic mr, input logic [31:0] mt);
        logic        redir;
        logic        e_valid;
        logic        e_en;
        logic [31:0] tgt;
        id_allow_in = allow;
        br_taken    = br;
        br_target   = bt;
        trap_valid  = tr;
        trap_target = tt;
        mret_valid  = mr;
        mret_target = mt;
        #1;
        redir   = tr | mr | br;
        e_valid = m_valid && !redir;
        e_en    = allow && e_valid && !misaligned(m_pc);
        chk("irom_addr", {33'd0, irom_addr}, {33'd0, m_pc});
        chk("valid", {64'd0, if_to_id_valid}, {64'd0, e_valid});
        chk("irom_en", {64'd0, irom_en}, {64'd0, e_en});
        chk("bus", if_to_id_bus, {misaligned(m_pc), m_pc + 32'd4, m_pc});
        tgt = tr ? tt : (mr ? mt : bt);
`ifndef IF_MISALIGN_CHECK_EN
        tgt = tgt & 32'hFFFF_FFFC;
`endif
        if (redir)     m_pc = tgt;
        else if (e_en) m_pc = m_pc + 32'd4;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        br_taken   = 1'b0;
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input logic allow);
        step(allow, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic branch(input logic [31:0] t);
        step(1'b1, 1'b1, t, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    logic [31:0] rt;

    initial begin
        npass = 0;
        ntotal = 0;
        rst = 1'b1;
        id_allow_in = 1'b0;
        br_taken = 1'b0;
        br_target = 32'd0;
        trap_valid = 1'b0;
        trap_target = 32'd0;
        mret_valid = 1'b0;
        mret_target = 32'd0;
        m_pc = 32'd0;
        m_valid = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_addr", {33'd0, irom_addr}, 65'd0);
        chk("rst_en", {64'd0, irom_en}, 65'd0);
        chk("rst_valid", {64'd0, if_to_id_valid}, 65'd0);
        chk("rst_bus", if_to_id_bus, {1'b0, 32'h4, 32'h0});
        rst = 1'b0;

        // cycle 0 offers nothing, then 0x0, 0x4, 0x8 one per cycle
        run(1'b1);
        chk("seq_pc0", {33'd0, irom_addr}, 65'h0);
        run(1'b1);
        chk("seq_pc1", {33'd0, irom_addr}, 65'h4);
        run(1'b1);
        chk("seq_pc2", {33'd0, irom_addr}, 65'h8);
        repeat (3) begin
            run(1'b0);
            chk("stall_pc", {33'd0, irom_addr}, 65'h8);
        end
        run(1'b1);
        chk("resume_pc", {33'd0, irom_addr}, 65'hC);

        branch(32'h100);
        chk("br_pc", {33'd0, irom_addr}, 65'h100);
        chk("br_valid", {64'd0, if_to_id_valid}, 65'd1);
        step(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        chk("trap_prio", {33'd0, irom_addr}, 65'h80);
        step(1'b1, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 32'h40);
        chk("mret_prio", {33'd0, irom_addr}, 65'h40);
        step(1'b0, 1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("stall_redir", {33'd0, irom_addr}, 65'h200);

        branch(32'hFFFF_FFFC);
        chk("wrap_pc4", {33'd0, if_to_id_bus[63:32]}, 65'd0);
        run(1'b1);
        chk("wrap_pc", {33'd0, irom_addr}, 65'd0);

        branch(32'h102);
`ifdef IF_MISALIGN_CHECK_EN
        chk("mis_pc", {33'd0, irom_addr}, 65'h102);
        chk("mis_exc", {64'd0, if_to_id_bus[64]}, 65'd1);
        run(1'b1);
        chk("mis_hold", {33'd0, irom_addr}, 65'h102);
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'h80, 1'b0, 32'd0);
        chk("mis_trap", {33'd0, irom_addr}, 65'h80);
`else
        chk("mis_pc", {33'd0, irom_addr}, 65'h100);
        chk("mis_exc", {64'd0, if_to_id_bus[64]}, 65'd0);
`endif

        // asynchronous reset in the middle of a cycle
        branch(32'h20);
        chk("pre_rst_pc", {33'd0, irom_addr}, 65'h20);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_addr", {33'd0, irom_addr}, 65'd0);
        chk("arst_valid", {64'd0, if_to_id_valid}, 65'd0);
        chk("arst_en", {64'd0, irom_en}, 65'd0);
        chk("arst_bus", if_to_id_bus, {1'b0, 32'h4, 32'h0});
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'd0;
        m_valid = 1'b0;

        for (int i = 0; i < 400; i++) begin
            rt = $urandom;
            if ($urandom_range(0, 4) != 0) rt[1:0] = 2'b00;
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 6) == 0, rt,
                 $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
